// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Next-PC controller for the 16-bit word-addressed core. Walks the external
// Pc register through FETCH/EXEC, runs the instruction-fetch handshake and
// selects the next PC among sequential, branch, jump, interrupt entry and
// return-from-interrupt.
//
// The external Pc register loads PcNext on every Clk edge, so whenever the
// PC must not move this block drives PcNext = PcCurrent.
//
// Ports:
//   Clk          in   system clock, rising edge
//   RstN         in   asynchronous active-low reset
//   PcCurrent    in   [15:0] current PC (Pc.PcOutput)
//   PcNext       out  [15:0] next PC (Pc.PcInput), combinational
//   FetchReq     out  fetch request, address = PcCurrent (registered)
//   FetchAck     in   imem accepts/returns the instruction this cycle
//   Stall        in   hold EXEC
//   BranchTaken  in   conditional branch resolved taken
//   BranchOffset in   [15:0] signed word offset
//   Jump         in   absolute jump
//   JumpTarget   in   [15:0] absolute target
//   Reti         in   return from interrupt
//   Halt         in   halt instruction
//   Irq          in   level interrupt request
//   IrqAck       out  one-cycle pulse per interrupt entry (registered)
//   State        out  [1:0] 00 RESET, 01 FETCH, 10 EXEC, 11 HALTED
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0010
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic [15:0] PcCurrent,
    output logic [15:0] PcNext,
    output logic        FetchReq,
    input  logic        FetchAck,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [15:0] JumpTarget,
    input  logic        Reti,
    input  logic        Halt,
    input  logic        Irq,
    output logic        IrqAck,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t      state_r;
    logic        fetch_req_r;
    logic        irq_ack_r;
    logic        irq_en_r;
    logic [15:0] epc_r;

    logic [15:0] seq_pc_s;
    logic [15:0] branch_pc_s;
    logic [15:0] exec_pc_s;
    logic        irq_take_s;
    logic        reti_sel_s;
    logic [15:0] pc_next_s;

    // Candidate addresses; all arithmetic wraps modulo 2^16.
    always_comb begin
        seq_pc_s    = PcCurrent + 16'd1;
        branch_pc_s = seq_pc_s + BranchOffset;
        irq_take_s  = Irq & irq_en_r;
        reti_sel_s  = Reti & ~Jump & ~BranchTaken;
        // Jump > branch > reti > sequential; also the return address saved
        // when an interrupt preempts this instruction.
        if (Jump) begin
            exec_pc_s = JumpTarget;
        end else if (BranchTaken) begin
            exec_pc_s = branch_pc_s;
        end else if (Reti) begin
            exec_pc_s = epc_r;
        end else begin
            exec_pc_s = seq_pc_s;
        end
    end

    // Next-PC select; reset overrides asynchronously so Pc loads the vector.
    always_comb begin
        pc_next_s = PcCurrent;
        if (!RstN) begin
            pc_next_s = RESET_VECTOR;
        end else begin
            case (state_r)
                ST_RESET: pc_next_s = RESET_VECTOR;
                ST_FETCH: pc_next_s = PcCurrent;
                ST_EXEC: begin
                    if (Stall) begin
                        pc_next_s = PcCurrent;
                    end else if (irq_take_s) begin
                        pc_next_s = IRQ_VECTOR;
                    end else if (Halt) begin
                        pc_next_s = PcCurrent;
                    end else begin
                        pc_next_s = exec_pc_s;
                    end
                end
                ST_HALTED: begin
                    if (irq_take_s) begin
                        pc_next_s = IRQ_VECTOR;
                    end else begin
                        pc_next_s = PcCurrent;
                    end
                end
                default: pc_next_s = RESET_VECTOR;
            endcase
        end
    end

    // Sequencer FSM with registered FetchReq/IrqAck and interrupt context.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_r     <= ST_RESET;
            fetch_req_r <= 1'b0;
            irq_ack_r   <= 1'b0;
            irq_en_r    <= 1'b1;
            epc_r       <= 16'h0000;
        end else begin
            irq_ack_r <= 1'b0;
            case (state_r)
                ST_RESET: begin
                    state_r     <= ST_FETCH;
                    fetch_req_r <= 1'b1;
                end
                ST_FETCH: begin
                    if (FetchAck) begin
                        state_r     <= ST_EXEC;
                        fetch_req_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (Stall) begin
                        state_r <= ST_EXEC;
                    end else if (irq_take_s) begin
                        // A halt preempted by the interrupt resumes after itself.
                        epc_r       <= Halt ? seq_pc_s : exec_pc_s;
                        irq_en_r    <= 1'b0;
                        irq_ack_r   <= 1'b1;
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end else if (Halt) begin
                        state_r <= ST_HALTED;
                    end else begin
                        if (reti_sel_s) begin
                            irq_en_r <= 1'b1;
                        end else begin
                            irq_en_r <= irq_en_r;
                        end
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (irq_take_s) begin
                        epc_r       <= seq_pc_s;
                        irq_en_r    <= 1'b0;
                        irq_ack_r   <= 1'b1;
                        state_r     <= ST_FETCH;
                        fetch_req_r <= 1'b1;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                default: begin
                    state_r     <= ST_RESET;
                    fetch_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign PcNext   = pc_next_s;
    assign FetchReq = fetch_req_r;
    assign IrqAck   = irq_ack_r;
    assign State    = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench: models the external Pc register, drives directed and
// random stimulus and compares every cycle against a behavioural model of
// the sequencing rules.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [15:0] RV  = 16'h0000;
    localparam logic [15:0] IV  = 16'h0010;

    localparam int M_RESET  = 0;
    localparam int M_FETCH  = 1;
    localparam int M_EXEC   = 2;
    localparam int M_HALTED = 3;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic [15:0] pc_q;
    logic [15:0] PcNext;
    logic        FetchReq;
    logic        FetchAck = 1'b0;
    logic        Stall = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchOffset = 16'h0000;
    logic        Jump = 1'b0;
    logic [15:0] JumpTarget = 16'h0000;
    logic        Reti = 1'b0;
    logic        Halt = 1'b0;
    logic        Irq = 1'b0;
    logic        IrqAck;
    logic [1:0]  State;

    int err_cnt = 0;
    int chk_cnt = 0;

    // model state
    int          m_mode;
    logic [15:0] m_pc;
    logic [15:0] m_epc;
    logic        m_ien;
    logic        m_ack;

    pc_sequencer #(.RESET_VECTOR(RV), .IRQ_VECTOR(IV)) dut (
        .Clk(Clk), .RstN(RstN), .PcCurrent(pc_q), .PcNext(PcNext),
        .FetchReq(FetchReq), .FetchAck(FetchAck), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .Jump(Jump), .JumpTarget(JumpTarget), .Reti(Reti), .Halt(Halt),
        .Irq(Irq), .IrqAck(IrqAck), .State(State)
    );

    always #5 Clk = ~Clk;

    // External Pc register: loads PcNext on every edge
    always_ff @(posedge Clk) pc_q <= PcNext;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RESET;
        m_pc   = RV;
        m_epc  = 16'h0000;
        m_ien  = 1'b1;
        m_ack  = 1'b0;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic cyc(input logic st, input logic irq, input logic hlt,
                       input logic jmp, input logic br, input logic rti,
                       input logic fack, input logic [15:0] off,
                       input logic [15:0] tgt);
        logic [15:0] exp_next;
        logic [15:0] normal;
        int          nxt_mode;
        logic        nxt_ack;
        Stall = st; Irq = irq; Halt = hlt; Jump = jmp; BranchTaken = br;
        Reti = rti; FetchAck = fack; BranchOffset = off; JumpTarget = tgt;
        #1;
        chk("state", {14'd0, State}, 16'(m_mode));
        chk("fetchreq", {15'd0, FetchReq}, {15'd0, (m_mode == M_FETCH)});
        chk("irqack", {15'd0, IrqAck}, {15'd0, m_ack});
        chk("pccur", pc_q, m_pc);

        nxt_ack  = 1'b0;
        exp_next = m_pc;
        nxt_mode = m_mode;
        if (jmp)      normal = tgt;
        else if (br)  normal = m_pc + 16'd1 + off;
        else if (rti) normal = m_epc;
        else          normal = m_pc + 16'd1;
        case (m_mode)
            M_RESET: begin exp_next = RV; nxt_mode = M_FETCH; end
            M_FETCH: begin exp_next = m_pc; nxt_mode = fack ? M_EXEC : M_FETCH; end
            M_EXEC: begin
                if (st) begin
                    exp_next = m_pc;
                end else if (irq && m_ien) begin
                    m_epc = hlt ? m_pc + 16'd1 : normal;
                    exp_next = IV; m_ien = 1'b0; nxt_ack = 1'b1; nxt_mode = M_FETCH;
                end else if (hlt) begin
                    exp_next = m_pc; nxt_mode = M_HALTED;
                end else begin
                    if (!jmp && !br && rti) m_ien = 1'b1;
                    exp_next = normal; nxt_mode = M_FETCH;
                end
            end
            default: begin
                if (irq && m_ien) begin
                    m_epc = m_pc + 16'd1;
                    exp_next = IV; m_ien = 1'b0; nxt_ack = 1'b1; nxt_mode = M_FETCH;
                end else begin
                    exp_next = m_pc;
                end
            end
        endcase
        chk("pcnext", PcNext, exp_next);
        m_pc = exp_next; m_mode = nxt_mode; m_ack = nxt_ack;
        @(posedge Clk); #1;
    endtask

    task automatic idle(input logic fack);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fack, 16'h0000, 16'h0000);
    endtask

    // Asynchronous reset assertion mid-cycle, then release
    task automatic do_reset();
        #2;
        RstN = 1'b0;
        #1;
        chk("rst_fetchreq", {15'd0, FetchReq}, 16'h0000);
        chk("rst_pcnext", PcNext, RV);
        chk("rst_state", {14'd0, State}, 16'h0000);
        @(posedge Clk); @(posedge Clk); #1;
        RstN = 1'b1;
        model_reset();
    endtask

    initial begin
        int stuck;
        model_reset();
        @(posedge Clk); @(posedge Clk); #1;
        RstN = 1'b1;

        // Sequential run: RESET, then FETCH/EXEC pairs
        repeat (5) idle(1'b1);
        chk("seq_pc", pc_q, 16'h0002);

        // Fetch wait: ack withheld 3 cycles
        repeat (3) idle(1'b0);
        chk("fetch_wait_req", {15'd0, FetchReq}, 16'h0001);
        idle(1'b1);
        idle(1'b1);
        chk("after_wait_pc", pc_q, 16'h0003);

        // Wrap FFFF -> 0000
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF);
        chk("jump_ffff", pc_q, 16'hFFFF);
        idle(1'b1);
        idle(1'b1);
        chk("wrap", pc_q, 16'h0000);

        // Branch 0002 + 1 + FFF0 = FFF3
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002);
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFF0, 16'h0000);
        chk("branch_neg", pc_q, 16'hFFF3);

        // Jump beats branch
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h1234);
        chk("jump_prio", pc_q, 16'h1234);

        // Interrupt during jump, held Irq, Reti, re-entry
        idle(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0400);
        chk("irq_vec", pc_q, 16'h0010);
        chk("irq_ack", {15'd0, IrqAck}, 16'h0001);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        chk("reti_pc", pc_q, 16'h0400);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        chk("irq_again", pc_q, 16'h0010);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);

        // Halt, stay, then interrupt out with Epc = halt PC + 1
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        repeat (10) idle(1'b1);
        chk("halted", {14'd0, State}, 16'h0003);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        chk("halt_irq", pc_q, 16'h0010);

        // Stall holds the PC, even with Irq
        do_reset();
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0055);
        chk("stall_hold", pc_q, 16'h0000);
        idle(1'b1);
        chk("stall_rel", pc_q, 16'h0001);

        // Random phase
        stuck = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] off;
            logic [15:0] tgt;
            off = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if (m_mode == M_HALTED) stuck++;
            else stuck = 0;
            if (stuck > 12 || $urandom_range(0, 299) == 0) begin
                do_reset();
                stuck = 0;
            end else begin
                cyc($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) != 0, off, tgt);
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the 16-bit core. It sequences the Pc register through fetch/execute and handles the instruction-memory fetch handshake.
- It selects the next PC among sequential, branch, jump, interrupt and return-from-interrupt.
- PcNext drives Pc.PcInput. Pc.PcOutput feeds back as PcCurrent. Pc loads every Clk edge, so this block holds PcNext = PcCurrent whenever the PC must not move.
- Word-addressed: one instruction per 16-bit word, so sequential step is +1.

Parameters:
- RESET_VECTOR, 16'h0000, PC value forced during and immediately after reset.
- IRQ_VECTOR, 16'h0010, interrupt handler entry address.

Ports:
- Clk  input  1  system clock, rising edge
- RstN  input  1  asynchronous active-low reset
- PcCurrent  input  16  current PC from Pc.PcOutput
- PcNext  output  16  next PC to Pc.PcInput
- FetchReq  output  1  instruction fetch request, address = PcCurrent
- FetchAck  input  1  imem accepts/returns instruction this cycle
- Stall  input  1  hold EXEC (datapath hazard)
- BranchTaken  input  1  conditional branch resolved taken
- BranchOffset  input  16  signed word offset
- Jump  input  1  absolute jump
- JumpTarget  input  16  absolute target
- Reti  input  1  return from interrupt
- Halt  input  1  halt instruction
- Irq  input  1  level interrupt request
- IrqAck  output  1  one-cycle pulse on interrupt entry
- State  output  2  00 RESET, 01 FETCH, 10 EXEC, 11 HALTED

Behaviour:
- Reset (RstN low, async): State=RESET, FetchReq=0, IrqAck=0, IrqEn=1, Epc=16'h0000. PcNext=RESET_VECTOR combinationally while RstN low, so Pc loads RESET_VECTOR.
- RESET: PcNext=RESET_VECTOR. Next edge goes to FETCH.
- FETCH: FetchReq=1, PcNext=PcCurrent (hold).
  - FetchAck=1 → EXEC next edge.
  - FetchReq stays high until ack; no timeout.
- EXEC: FetchReq=0. Evaluate in fixed priority, 1 cycle unless stalled:
  1. Stall=1: PcNext=PcCurrent, stay EXEC. All other inputs ignored this cycle, including Irq.
  2. Irq=1 and IrqEn=1:
     - Epc <= normal next PC, i.e. the result of rules 3-7 (taken branch/jump not lost).
     - PcNext=IRQ_VECTOR, IrqEn<=0, IrqAck=1 this cycle, then FETCH.
     - If Halt=1 in this same cycle, the interrupt wins and Epc = PcCurrent+1.
  3. Halt=1: PcNext=PcCurrent, go HALTED.
  4. Jump=1: PcNext=JumpTarget, then FETCH.
  5. BranchTaken=1: PcNext=PcCurrent+1+BranchOffset, then FETCH.
  6. Reti=1: PcNext=Epc, IrqEn<=1, then FETCH.
  7. Otherwise: PcNext=PcCurrent+1, then FETCH.
- HALTED: PcNext=PcCurrent, FetchReq=0.
  - Irq=1 with IrqEn=1: Epc<=PcCurrent+1, PcNext=IRQ_VECTOR, IrqAck=1, IrqEn<=0, then FETCH.
  - Otherwise exit only by reset.
- Arithmetic: all 16-bit, modulo 2^16, carries discarded. Examples: FFFF+1 → 0000; 0002+1+FFF0 → FFF3.
- Interrupts:
  - Irq is masked while IrqEn=0; no nesting.
  - Irq still high when Reti re-enables is taken at the next EXEC.
  - Reti while IrqEn=1 still loads Epc (software error, no trap).
- IrqAck: exactly one Clk cycle per entry, registered with the transition.
- Reset mid-FETCH or mid-EXEC: immediate return to RESET; FetchReq drops asynchronously; in-flight FetchAck ignored.
- Throughput: no-stall sequential code retires one instruction per 2 cycles (FETCH+EXEC) with zero-wait imem.

Test Plan:
- Reset release, FetchAck tied 1, no control inputs → PcCurrent sequence 0000,0000,0001,0001,0002…; State alternates 01/10; FetchReq high in FETCH cycles only.
- FetchAck held low 3 cycles in FETCH at PC=0005 → FetchReq high 3+1 cycles, PcNext=0005 throughout, then EXEC, PC→0006.
- EXEC at PC=0008 with BranchTaken=1, BranchOffset=FFFA → PC=0003. Jump=1, JumpTarget=1234 with BranchTaken=1 simultaneously → PC=1234 (jump priority).
- Irq=1 in EXEC at PC=0020 with Jump to 0400 → IrqAck pulse 1 cycle, PC=0010, Epc=0400. Irq held high: no second ack. Reti in handler → PC=0400, and the still-high Irq is taken at the next EXEC.
- Halt at PC=0030 → State=11, PC stays 0030 for 10 cycles, FetchReq=0. Irq → PC=0010, Epc=0031. Stall=1 for 2 EXEC cycles at PC=0040 → PC holds 0040, then 0041.
- RstN pulled low mid-FETCH at PC=0077 → FetchReq=0 within same cycle (async). PcNext=0000 during reset; restart at RESET_VECTOR. PC=FFFF sequential → wraps to 0000.
